// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   i_req_valid;
  logic [8*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]   i_req_last;
  logic [N_REQ-1:0]   o_req_ready;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic [N_REQ-1:0]   o_grant;
  logic               o_busy;
  logic               o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among N_REQ byte streams,
// with an output holding register and an inactivity watchdog on the owner.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 250000
) (
  input logic              i_clk25MHz,
  input logic              i_reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]       state;
  logic [GW-1:0]    last_grant;
  logic [N_REQ-1:0] grant;
  logic             hold_full;
  logic [7:0]       hold_data;
  logic [CW-1:0]    wd_cnt;
  logic             timeout;

  logic [GW-1:0]    winner;
  logic [GW:0]      cand;
  logic             any_req;
  logic             slot_ready;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             accept;
  logic             idle_tick;
  logic             wd_expire;

  // Walk offsets from the far end inward so the requester nearest to
  // last_grant+1 is written last and wins.
  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    winner = last_grant;
    cand   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = (GW+1)'(last_grant) + (GW+1)'(i);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (bus.i_req_valid[cand[GW-1:0]]) winner = cand[GW-1:0];
    end
  end

  assign any_req = |bus.i_req_valid;

  // last_grant doubles as the owner index while in XFER.
  assign g_valid    = bus.i_req_valid[last_grant];
  assign g_last     = bus.i_req_last[last_grant];
  assign g_data     = bus.i_req_data[{last_grant, 3'b000} +: 8];
  assign slot_ready = (state == ST_XFER) && (!hold_full || bus.i_tx_ready);
  assign accept     = slot_ready && g_valid;
  assign idle_tick  = slot_ready && !g_valid;
  // Counter is at LIMIT-1 and this idle cycle would make it reach the limit.
  assign wd_expire  = idle_tick && (wd_cnt == CW'(TIMEOUT_CYC - 1));

  assign bus.o_req_ready = slot_ready ? grant : '0;
  assign bus.o_tx_valid  = hold_full;
  assign bus.o_tx_data   = hold_data;
  assign bus.o_grant     = grant;
  assign bus.o_busy      = (state == ST_XFER) || hold_full;
  assign bus.o_timeout   = timeout;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk25MHz) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      last_grant <= GW'(N_REQ - 1);
      grant      <= '0;
      hold_full  <= 1'b0;
      // NOTE: the data register is reset too because o_tx_data must read 0 out of reset.
      hold_data  <= 8'h00;
      wd_cnt     <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;

      if (accept) begin
        hold_data <= g_data;
        hold_full <= 1'b1;
      end else if (hold_full && bus.i_tx_ready) begin
        hold_full <= 1'b0;
      end

      if (state == ST_IDLE) begin
        wd_cnt <= '0;
        if (any_req) begin
          state      <= ST_XFER;
          last_grant <= winner;
          grant      <= N_REQ'(1) << winner;
        end
      end else begin
        if (accept) begin
          wd_cnt <= '0;
          if (g_last) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end else if (wd_expire) begin
          // Offender stays in last_grant so it is searched last next round.
          state   <= ST_IDLE;
          grant   <= '0;
          wd_cnt  <= '0;
          timeout <= 1'b1;
        end else if (idle_tick) begin
          wd_cnt <= wd_cnt + CW'(1);
        end
      end
    end
  end
endmodule
